vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator that replaces the separate horizontal and vertical counters with one block.
- Produces pixel and line counts, sync pulses with programmable polarity, a video-active flag, and line and frame start strobes.
- Sits between the pixel clock-enable source and the Breakout renderer / VGA output pins.
- Advances only on a pixel clock-enable, so it runs from the system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 16, width of the h_count and v_count outputs

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- pix_en  input  1  pixel clock-enable; the raster advances one pixel per clk where this is high
- h_count  output  CW  current pixel column, 0..H_TOTAL-1
- v_count  output  CW  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity set by HS_POL
- vsync  output  1  vertical sync, polarity set by VS_POL
- video_on  output  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_start  output  1  one-clk pulse when h_count advances to 0
- frame_start  output  1  one-clk pulse when h_count and v_count both advance to 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Every parameter except the polarities must be at least 1.
  - Both totals must be less than 2^CW; elaboration fails otherwise.
- Region order per line: active, front porch, sync, back porch. Lines within a frame use the same order.
- hsync is active when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC. vsync is active over the equivalent range of v_count.
- All outputs are registered and always decode the h_count/v_count values presented in the same cycle (zero skew between counts and flags).
- Reset values:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1
  - video_on = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - line_start = 0, frame_start = 0
- Because reset parks the raster in the last back-porch pixel, the first pix_en after reset wraps to (0,0) with frame_start high.
- Advance on clk with pix_en = 1:
  - If h_count < H_TOTAL-1, h_count increments.
  - Otherwise h_count goes to 0 and v_count advances: it increments if below V_TOTAL-1, else goes to 0.
- pix_en = 0: counts, hsync, vsync and video_on hold their values.
- line_start and frame_start are high for exactly one clk, in the cycle the new (wrapped) counts appear. They clear on the next clk regardless of pix_en.
- Reset has priority over pix_en. Reset mid-line or mid-frame returns every output to its reset value on the next clk edge. No partial-line state is retained.
- Counts saturate nowhere; the only wrap points are H_TOTAL-1 and V_TOTAL-1.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset value 0.
  - frame_count increments in the same clk that frame_start is asserted and wraps from 65535 to 0.
  - The first frame_start after reset sets it to 1.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then one clk with pix_en = 1 -> h_count=0, v_count=0, video_on=1, frame_start=1 and line_start=1 for one clk, hsync=1, vsync=1 (defaults).
- Defaults, pix_en held high for 800 clks after the first advance -> h_count=0, v_count=1, line_start pulses. hsync is 0 exactly for h_count 656..751 and video_on is 0 for h_count >= 640.
- Defaults, 420000 pix_en clks -> frame_start pulses again at (0,0). vsync is 0 only on lines 490..491 and video_on is 0 on lines >= 480.
- pix_en toggled 1,0,0,1 from h_count=10 -> counts read 11,11,11,12; line_start never asserts; hsync and video_on are stable while stalled.
- Reset asserted at h_count=300, v_count=200 -> next clk h_count=799, v_count=524, video_on=0, syncs inactive; the next pix_en gives frame_start.
- Override params H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, HS_POL=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 -> hsync=1 only for h_count 5..6; frame period = 40 pix_en clks. With VGA_TIMING_FRAME_CNT_EN defined, frame_count=3 after 3 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, video-active flag and start strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame_count output.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   output logic [CW-1:0] h_count,
   output logic [CW-1:0] v_count,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_param
         $error("vga_timing_gen: every timing parameter and CW must be at least 1");
      end
      if ((longint'(H_TOTAL) >> CW) != 0 || (longint'(V_TOTAL) >> CW) != 0) begin : g_bad_width
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must be less than 2**CW");
      end
   endgenerate

   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          wrap_h, wrap_v;
   logic          hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      wrap_h = 1'b0;
      wrap_v = 1'b0;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d    = '0;
            wrap_h = 1'b1;
            if (v_q == V_LAST) begin
               v_d    = '0;
               wrap_v = 1'b1;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Flags decode the next counts so they land in the same cycle as the counts they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hsync_q       <= (h_d >= HS_START && h_d < HS_END) ? HS_POL : ~HS_POL;
         vsync_q       <= (v_d >= VS_START && v_d < VS_END) ? VS_POL : ~VS_POL;
         video_on_q    <= (h_d < H_ACT) && (v_d < V_ACT);
         line_start_q  <= wrap_h;
         frame_start_q <= wrap_h & wrap_v;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else if (wrap_h && wrap_v) begin
         frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign frame_count = frame_cnt_q;
`endif

   assign h_count     = h_q;
   assign v_count     = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
